mem_io_responder: RTL
=====================

// Module: mem_io_responder
// PURPOSE
// - Target end of the CPU byte bus (mem_a/mem_wr/CPU data out -> this block; read data -> CPU data in).
// - Serves 128KB byte RAM and the 0x3xxxx I/O window: UART RX byte read, cycle counter read, UART TX write, program stop.
// - Owns the TX byte queue and drives io_buffer_full back to the CPU.
// - Sits between cpu and the UART/board wrapper; replaces the behavioural RAM model in simulation.
// PARAMETERS
// - RAM_ADDR_WIDTH  17  byte-address bits of RAM (128KB)
// - TXQ_WIDTH       3   log2 depth of TX byte queue (8 entries)
// - FULL_MARGIN     2   free slots still left when io_buffer_full rises (covers in-flight CPU writes)
// PORTS
// - clk_in        in   1   clock
// - rst_in        in   1   synchronous reset, active-high
// - mem_a         in   32  byte address from CPU (only [17:0] decoded)
// - mem_wr        in   1   1 = write this cycle, 0 = read
// - mem_wdata     in   8   write data from CPU (CPU mem_dout)
// - mem_rdata     out  8   read data to CPU (CPU mem_din), registered
// - io_buffer_full out 1   TX queue near full; CPU must not issue 0x30000/0x30004 writes
// - tx_data       out  8   byte to UART transmitter
// - tx_valid      out  1   tx_data valid (queue non-empty)
// - tx_ready      in   1   UART accepts tx_data this cycle
// - rx_data       in   8   head byte of UART receive queue
// - rx_empty      in   1   UART receive queue empty
// - rx_pop        out  1   one-cycle pulse: consume rx_data
// - program_stop  out  1   sticky; set by write to 0x30004
// BEHAVIOUR
// - Reset: mem_rdata=0, tx_valid=0, rx_pop=0, program_stop=0, io_buffer_full=0, cycle counter=0, TX queue empty. RAM contents not reset.
// - Decode: io = (mem_a[17:16]==2'b11); else RAM at mem_a[RAM_ADDR_WIDTH-1:0]. Every cycle is a transaction (no valid strobe).
// - RAM write: mem_wr=1, !io -> byte stored at posedge; mem_rdata unchanged. Read issued next cycle returns new value.
// - RAM read: mem_wr=0 -> mem_rdata = RAM[addr] after the posedge (1-cycle latency, exactly).
// - Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF->0.
// - Read 0x30000: mem_rdata = rx_empty ? 8'h00 : rx_data; rx_pop pulses for that cycle only if !rx_empty.
// - Read 0x30004: snapshot counter into 32-bit latch; mem_rdata = counter[7:0]. Reads 0x30005/6/7 return snapshot bytes 1/2/3 (little-endian); they never re-snapshot.
// - Reads of other I/O addresses return 8'h00, no side effect.
// - Write 0x30000: push mem_wdata to TX queue unless value==8'h00 (ignored).
// - Write 0x30004: push 8'h00 to TX queue and set program_stop (stays set until reset).
// - Other I/O writes ignored.
// - TX queue: push and pop (tx_valid&tx_ready) same cycle -> occupancy unchanged, both take effect; pointers wrap mod 2^TXQ_WIDTH.
// - Push when full: byte dropped, occupancy unchanged (protocol violation; bench flags it).
// - io_buffer_full = registered (occupancy >= 2^TXQ_WIDTH - FULL_MARGIN); updates one cycle after occupancy change.
// - tx_data/tx_valid reflect queue head combinationally from queue storage; tx_valid=0 when empty.
// - Reset mid-transaction: pending read result lost, mem_rdata=0 next cycle, queue flushed.
// STRUCTURE
// - Package mem_map_pkg: IO_SEL=2'b11, ADDR_UART=18'h30000, ADDR_CLK=18'h30004, RAM_BYTES.
// - Sub-module byte_fifo (parameter WIDTH): push/pop/full/empty/count; instantiated once for TX queue.
// - Top holds RAM array, decode, counter + snapshot latch, rdata register, full-flag register.
// TESTING
// - Write 8'hA5 to 0x00010, then read 0x00010 -> mem_rdata==8'hA5 on the cycle after the read address.
// - Back-to-back write 0x1 to 0x1FFFF then read 0x1FFFF -> 8'h01 (top-of-RAM boundary, no IO alias).
// - Write 'H','i',0x00 to 0x30000 with tx_ready=1 -> tx stream exactly 8'h48, 8'h69; zero dropped.
// - Hold tx_ready=0, write 6 bytes -> io_buffer_full=1 one cycle after 6th push; 3 more writes -> queue holds 8, 9th dropped.
// - After 0x100 cycles from reset read 0x30004..0x30007 -> bytes of one snapshot (8'h00,8'h01,8'h00,8'h00 ±latency), consistent even as counter advances.
// - rx_empty=1 read 0x30000 -> 8'h00, no rx_pop; write 0x30004 -> program_stop=1 and 8'h00 emitted on tx.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map, access classification and shared constants for the CPU byte bus target.
package mem_map_pkg;

    localparam logic [1:0]  IO_SEL    = 2'b11;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CLK  = 18'h30004;
    localparam int unsigned RAM_BYTES = 1 << 17;

    typedef enum logic [2:0] {
        ACC_RAM,
        ACC_UART,
        ACC_CLK,
        ACC_SNAP,
        ACC_IO_OTHER
    } acc_e;

    // Classify the decoded low address bits into one access kind.
    function automatic acc_e decode_addr(input logic [17:0] a);
        acc_e acc;
        if (a[17:16] != IO_SEL) begin
            acc = ACC_RAM;
        end else if (a == ADDR_UART) begin
            acc = ACC_UART;
        end else if (a == ADDR_CLK) begin
            acc = ACC_CLK;
        end else if (a[17:2] == ADDR_CLK[17:2]) begin
            acc = ACC_SNAP;
        end else begin
            acc = ACC_IO_OTHER;
        end
        return acc;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with 2**WIDTH entries; pushes into a full queue are dropped.
module byte_fifo #(
    parameter int unsigned WIDTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [7:0]     push_data,
    input  logic           pop,
    output logic [7:0]     pop_data,
    output logic           full,
    output logic           empty,
    output logic [WIDTH:0] count
);

    localparam logic [WIDTH:0] DEPTH = {1'b1, {WIDTH{1'b0}}};

    logic [7:0]       mem_q [2**WIDTH];
    logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    // Qualify push/pop against occupancy and advance pointers and count.
    always_comb begin
        push_ok  = push && (count_q != DEPTH);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus target: 128KB RAM plus UART RX/TX, cycle counter and program-stop I/O window.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TXQ_WIDTH      = 3,
    parameter int unsigned FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_pop,
    output logic        program_stop
);

    import mem_map_pkg::*;

    localparam int unsigned    FULL_LEVEL_INT = (2**TXQ_WIDTH) - FULL_MARGIN;
    localparam logic [TXQ_WIDTH:0] FULL_LEVEL = FULL_LEVEL_INT[TXQ_WIDTH:0];

    logic [7:0]                ram_q [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    acc_e                      acc;

    logic [7:0]  mem_rdata_q, mem_rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        stop_q, stop_d;
    logic        full_q, full_d;

    logic           txq_push;
    logic [7:0]     txq_push_data;
    logic           txq_empty;
    logic [TXQ_WIDTH:0] txq_count;
    logic           unused_txq_full;
    logic           rx_pop_c;
    logic           addr_unused;

    assign ram_addr    = mem_a[RAM_ADDR_WIDTH-1:0];
    assign addr_unused = ^mem_a[31:18];

    // Decode the bus cycle: read data selection, I/O side effects and TX pushes.
    always_comb begin
        acc           = decode_addr(mem_a[17:0]);
        mem_rdata_d   = mem_rdata_q;
        snap_d        = snap_q;
        stop_d        = stop_q;
        cnt_d         = cnt_q + 32'd1;
        txq_push      = 1'b0;
        txq_push_data = mem_wdata;
        rx_pop_c      = 1'b0;
        full_d        = (txq_count >= FULL_LEVEL);
        if (!mem_wr) begin
            case (acc)
                ACC_RAM: mem_rdata_d = ram_q[ram_addr];
                ACC_UART: begin
                    mem_rdata_d = rx_empty ? 8'h00 : rx_data;
                    rx_pop_c    = !rx_empty;
                end
                ACC_CLK: begin
                    snap_d      = cnt_q;
                    mem_rdata_d = cnt_q[7:0];
                end
                ACC_SNAP: mem_rdata_d = snap_q[{mem_a[1:0], 3'b000} +: 8];
                default:  mem_rdata_d = 8'h00;
            endcase
        end else begin
            case (acc)
                ACC_UART: txq_push = (mem_wdata != 8'h00);
                ACC_CLK: begin
                    txq_push      = 1'b1;
                    txq_push_data = 8'h00;
                    stop_d        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered bus/status state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_rdata_q <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            stop_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            mem_rdata_q <= mem_rdata_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            stop_q      <= stop_d;
            full_q      <= full_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && (acc == ACC_RAM)) begin
            ram_q[ram_addr] <= mem_wdata;
        end
    end

    byte_fifo #(
        .WIDTH (TXQ_WIDTH)
    ) u_txq (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (txq_push),
        .push_data (txq_push_data),
        .pop       (tx_valid && tx_ready),
        .pop_data  (tx_data),
        .full      (unused_txq_full),
        .empty     (txq_empty),
        .count     (txq_count)
    );

    assign tx_valid       = !txq_empty;
    assign mem_rdata      = mem_rdata_q;
    assign io_buffer_full = full_q;
    assign program_stop   = stop_q;
    assign rx_pop         = rx_pop_c && !rst_in;

endmodule
